game_setup_selector: RTL and testbench

//  Difficulty-selection stage of the game setup path, directly upstream of the setup latch.

---
 rtl/game_setup_selector_if.sv | 26 ++
 rtl/game_setup_selector.sv | 148 ++++++++++++++
 tb/tb_game_setup_selector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/game_setup_selector_if.sv
// Button inputs and difficulty/setup outputs of the game setup selector.
// master: upstream button/debounce side and game engine; slave: the selector itself.
interface game_setup_selector_if #(
    parameter int BOARD_W = 5,
    parameter int MINE_W  = 8
);
    logic               btn_up;
    logic               btn_down;
    logic               btn_confirm;
    logic               game_over;
    logic [1:0]         level;
    logic [BOARD_W-1:0] board_size;
    logic [MINE_W-1:0]  mine_count;
    logic               setup_valid;
    logic               locked;

    modport master (
        output btn_up, btn_down, btn_confirm, game_over,
        input  level, board_size, mine_count, setup_valid, locked
    );

    modport slave (
        input  btn_up, btn_down, btn_confirm, game_over,
        output level, board_size, mine_count, setup_valid, locked
    );
endinterface

// File: rtl/game_setup_selector.sv
// Difficulty selection for game setup. Up/down buttons (with auto-repeat
// while held) cycle through three levels; confirm issues a one-cycle
// setup_valid strobe and locks the selection until game_over.
module game_setup_selector #(
    parameter int          BOARD_W      = 5,
    parameter int          MINE_W       = 8,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    game_setup_selector_if.slave bus
);
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_COMMIT = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [MINE_W-1:0]  mine_q, mine_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rep_q, rep_d;
    logic               up_q, down_q, confirm_q;

    logic up_press, down_press, confirm_press;
    logic step;

    assign up_press      = bus.btn_up      & ~up_q;
    assign down_press    = bus.btn_down    & ~down_q;
    assign confirm_press = bus.btn_confirm & ~confirm_q;

    // State, outputs, repeat counter and button history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SELECT;
            level_q   <= 2'd0;
            board_q   <= BOARD_W'(8);
            mine_q    <= MINE_W'(10);
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            confirm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            board_q   <= board_d;
            mine_q    <= mine_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            up_q      <= bus.btn_up;
            down_q    <= bus.btn_down;
            confirm_q <= bus.btn_confirm;
        end
    end

    // Next state, level stepping with auto-repeat, and registered output values.
    // cnt_q == 0 means no repeat is armed; it only arms on a genuine press, so a
    // button still held from before (or after up+down overlap) never repeats.
    // rep_q selects which interval is being timed: initial delay or repeat rate.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        step    = 1'b0;

        case (state_q)
            S_SELECT: begin
                if (confirm_press) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                end else if (bus.btn_up == bus.btn_down) begin
                    cnt_d = '0;
                    rep_d = 1'b0;
                end else if (bus.btn_up ? up_press : down_press) begin
                    step  = 1'b1;
                    cnt_d = CW'(1);
                    rep_d = 1'b0;
                end else if (cnt_q != '0) begin
                    if (!rep_q && cnt_q == CW'(REPEAT_DELAY)) begin
                        step  = 1'b1;
                        cnt_d = CW'(1);
                        rep_d = 1'b1;
                    end else if (rep_q && cnt_q == CW'(REPEAT_RATE)) begin
                        step  = 1'b1;
                        cnt_d = CW'(1);
                    end else if (cnt_q != CW'(CNT_MAX)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_LOCKED;
                cnt_d   = '0;
                rep_d   = 1'b0;
            end
            S_LOCKED: begin
                cnt_d = '0;
                rep_d = 1'b0;
                if (bus.game_over) begin
                    state_d = S_SELECT;
                end
            end
            default: begin
                state_d = S_SELECT;
                cnt_d   = '0;
                rep_d   = 1'b0;
            end
        endcase

        if (step) begin
            if (bus.btn_up) begin
                level_d = (level_q == 2'd2) ? 2'd0 : level_q + 2'd1;
            end else begin
                level_d = (level_q == 2'd0) ? 2'd2 : level_q - 2'd1;
            end
        end

        case (level_d)
            2'd1:    begin board_d = BOARD_W'(12); mine_d = MINE_W'(25); end
            2'd2:    begin board_d = BOARD_W'(16); mine_d = MINE_W'(40); end
            default: begin board_d = BOARD_W'(8);  mine_d = MINE_W'(10); end
        endcase

        valid_d  = (state_d == S_COMMIT);
        locked_d = (state_d == S_LOCKED);
    end

    assign bus.level       = level_q;
    assign bus.board_size  = board_q;
    assign bus.mine_count  = mine_q;
    assign bus.setup_valid = valid_q;
    assign bus.locked      = locked_q;
endmodule

// File: tb/tb_game_setup_selector.sv
module tb_game_setup_selector;
    localparam int D = 8;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_setup_selector_if #(.BOARD_W(5), .MINE_W(8)) bus();

    game_setup_selector #(
        .BOARD_W(5),
        .MINE_W(8),
        .REPEAT_DELAY(D),
        .REPEAT_RATE(R)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: phase 0=selecting, 1=commit cycle, 2=game running
    int m_phase, m_level, m_hold_start, m_cyc;
    bit m_pu, m_pd, m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_level = 0; m_hold_start = -1; m_cyc = 0;
        m_pu = 0; m_pd = 0; m_pc = 0;
    endtask

    // one clock of the selector described by its rules
    task automatic model_step();
        bit up, dn, cf, go;
        int dir, t;
        up = bus.btn_up; dn = bus.btn_down; cf = bus.btn_confirm; go = bus.game_over;
        m_cyc++;
        case (m_phase)
            0: begin
                if (cf && !m_pc) begin
                    m_phase = 1;
                    m_hold_start = -1;
                end else if (up == dn) begin
                    m_hold_start = -1;
                end else begin
                    dir = up ? 1 : 2;
                    if (up ? !m_pu : !m_pd) begin
                        m_level = (m_level + dir) % 3;
                        m_hold_start = m_cyc;
                    end else if (m_hold_start >= 0) begin
                        t = m_cyc - m_hold_start;
                        if (t == D || (t > D && (t - D) % R == 0))
                            m_level = (m_level + dir) % 3;
                    end
                end
            end
            1: m_phase = 2;
            default: if (go) m_phase = 0;
        endcase
        m_pu = up; m_pd = dn; m_pc = cf;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".level"}, 32'(bus.level), 32'(m_level));
        check({tag, ".board"}, 32'(bus.board_size), 32'(8 + 4 * m_level));
        check({tag, ".mines"}, 32'(bus.mine_count), (m_level == 0) ? 10 : (m_level == 1) ? 25 : 40);
        check({tag, ".valid"}, 32'(bus.setup_valid), 32'(m_phase == 1));
        check({tag, ".locked"}, 32'(bus.locked), 32'(m_phase == 2));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic set_btn(input bit up, input bit dn, input bit cf, input bit go);
        bus.btn_up = up; bus.btn_down = dn; bus.btn_confirm = cf; bus.game_over = go;
    endtask

    initial begin
        set_btn(0, 0, 0, 0);
        model_reset();
        #12;
        check("rst.level", 32'(bus.level), 0);
        check("rst.board", 32'(bus.board_size), 8);
        check("rst.mines", 32'(bus.mine_count), 10);
        check("rst.valid", 32'(bus.setup_valid), 0);
        check("rst.locked", 32'(bus.locked), 0);
        rst_n = 1'b1;
        tick("idle");

        // three single-cycle up presses, then one down press
        for (int i = 0; i < 3; i++) begin
            set_btn(1, 0, 0, 0); tick("up_press");
            set_btn(0, 0, 0, 0); tick("up_rel");
        end
        check("three_up.level", 32'(bus.level), 0);
        set_btn(0, 1, 0, 0); tick("down_press");
        set_btn(0, 0, 0, 0); tick("down_rel");
        check("down_wrap.level", 32'(bus.level), 2);
        check("down_wrap.board", 32'(bus.board_size), 16);
        check("down_wrap.mines", 32'(bus.mine_count), 40);
        set_btn(1, 0, 0, 0); tick("to0");
        set_btn(0, 0, 0, 0); tick("to0_rel");

        // held up: steps at press, +8, +11, +14, +17, +20
        set_btn(1, 0, 0, 0);
        for (int i = 0; i <= 20; i++) tick("hold_up");
        set_btn(0, 0, 0, 0); tick("hold_rel");
        check("hold.level", 32'(bus.level), 0);

        // up + confirm at level 1
        set_btn(1, 0, 0, 0); tick("to1");
        set_btn(0, 0, 0, 0); tick("to1_rel");
        set_btn(1, 0, 1, 0); tick("up_confirm");
        check("commit.valid", 32'(bus.setup_valid), 1);
        check("commit.board", 32'(bus.board_size), 12);
        check("commit.mines", 32'(bus.mine_count), 25);
        set_btn(0, 0, 0, 0); tick("commit_next");
        check("lock.locked", 32'(bus.locked), 1);
        check("lock.valid", 32'(bus.setup_valid), 0);
        for (int i = 0; i < 3; i++) begin
            set_btn(1, 0, 0, 0); tick("lock_up");
            set_btn(0, 1, 0, 0); tick("lock_down");
            set_btn(0, 0, 0, 0); tick("lock_rel");
        end
        check("lock.level", 32'(bus.level), 1);

        // unlock, then one press, then game_over while selecting
        set_btn(0, 0, 0, 1); tick("game_over");
        set_btn(0, 0, 0, 0); tick("unlocked");
        check("unlock.locked", 32'(bus.locked), 0);
        set_btn(1, 0, 0, 0); tick("post_up");
        set_btn(0, 0, 0, 0); tick("post_rel");
        check("post.level", 32'(bus.level), 2);
        set_btn(0, 0, 0, 1); tick("go_select");
        set_btn(0, 0, 0, 0); tick("go_select_after");
        check("go_sel.locked", 32'(bus.locked), 0);
        check("go_sel.level", 32'(bus.level), 2);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            bit up, dn, cf, go;
            up = bus.btn_up; dn = bus.btn_down; cf = bus.btn_confirm;
            if ($urandom_range(0, 11) == 0) up = !up;
            if ($urandom_range(0, 13) == 0) dn = !dn;
            if ($urandom_range(0, 29) == 0) cf = !cf;
            go = ($urandom_range(0, 15) == 0);
            set_btn(up, dn, cf, go);
            tick("rand");
        end

        // reset during the commit cycle
        set_btn(0, 0, 0, 1); tick("pre_rst_go");
        set_btn(0, 0, 0, 0); tick("pre_rst_idle");
        set_btn(1, 0, 1, 0); tick("pre_rst_confirm");
        check("pre_rst.valid", 32'(bus.setup_valid), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst.valid", 32'(bus.setup_valid), 0);
        check("mid_rst.level", 32'(bus.level), 0);
        check("mid_rst.locked", 32'(bus.locked), 0);
        check("mid_rst.board", 32'(bus.board_size), 8);
        set_btn(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("after_rst");
        tick("after_rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
